// File: rtl/mac_stream_ctrl.sv
// mac_stream_ctrl: sequences column reads into 3x3 windows for the mac datapath.
// Optional drain watchdog enabled by defining MAC_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module mac_stream_ctrl #(
  parameter int AW      = 17,
  parameter int MAC_LAT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_len,
  output logic          o_mem_ren,
  output logic [AW-1:0] o_mem_addr,
  input  logic [23:0]   i_img_rdata,
  input  logic [23:0]   i_wgt_rdata,
  output logic [71:0]   o_win_im,
  output logic [35:0]   o_win_ker,
  output logic          o_mac_valid,
  input  logic          i_mac_valid,
  input  logic [15:0]   i_mac_conv,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [15:0]   o_wr_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [AW-1:0] n_len;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] wr_nxt;
  logic          rvalid;
  logic [1:0]    cols;
  logic          start_ok;
  logic          start_bad;
  logic          last_addr;
  logic          wr_fire;
  logic          drain_done;
  logic          wd_fire;

  // Weight lanes only carry a nibble; upper nibbles are don't-care.
  logic unused_wgt;
  assign unused_wgt = ^{i_wgt_rdata[23:20],
                        i_wgt_rdata[15:12],
                        i_wgt_rdata[7:4]};

  // State register.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-cycle strobes.
  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    last_addr  = (o_mem_addr == n_len - AW'(1));
    wr_fire    = i_mac_valid &&
                 (state_q == READ || state_q == DRAIN);
    wr_nxt     = wr_cnt + AW'(wr_fire);
    drain_done = (wr_nxt >= n_len - AW'(2));
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len >= AW'(3)) begin
            start_ok = 1'b1;
            state_d  = READ;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      READ: begin
        if (last_addr) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done || wd_fire) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pass control: length latch, read addressing, status pulses.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      n_len      <= '0;
      o_mem_ren  <= 1'b0;
      o_mem_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_err  <= start_bad;
      o_done <= 1'b0;
      if (start_ok) begin
        n_len      <= i_len;
        o_busy     <= 1'b1;
        o_mem_ren  <= 1'b1;
        o_mem_addr <= '0;
      end
      if (state_q == READ) begin
        if (last_addr) o_mem_ren <= 1'b0;
        else o_mem_addr <= o_mem_addr + AW'(1);
      end
      if (state_q == DRAIN && state_d == DONE) begin
        o_busy <= 1'b0;
        o_done <= 1'b1;
      end
    end
  end

  // Result capture into the output buffer.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      wr_cnt    <= '0;
    end else begin
      o_wr_en <= wr_fire;
      if (wr_fire) begin
        o_wr_addr <= wr_cnt;
        o_wr_data <= i_mac_conv;
      end
      if (start_ok) wr_cnt <= '0;
      else if (wr_fire) wr_cnt <= wr_nxt;
    end
  end

  // Column shift into the sliding window; valid once three columns are in.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rvalid      <= 1'b0;
      cols        <= '0;
      o_mac_valid <= 1'b0;
      o_win_im    <= '0;
      o_win_ker   <= '0;
    end else begin
      rvalid      <= o_mem_ren;
      o_mac_valid <= rvalid && (cols == 2'd2);
      if (start_ok) cols <= '0;
      else if (rvalid && cols != 2'd2) cols <= cols + 2'd1;
      if (rvalid) begin
        for (int r = 0; r < 3; r++) begin
          o_win_im[24*r +: 8]    <= o_win_im[24*r+8 +: 8];
          o_win_im[24*r+8 +: 8]  <= o_win_im[24*r+16 +: 8];
          o_win_im[24*r+16 +: 8] <= i_img_rdata[8*r +: 8];
          o_win_ker[12*r +: 4]   <= o_win_ker[12*r+4 +: 4];
          o_win_ker[12*r+4 +: 4] <= o_win_ker[12*r+8 +: 4];
          o_win_ker[12*r+8 +: 4] <= i_wgt_rdata[8*r +: 4];
        end
      end
    end
  end

`ifdef MAC_CTRL_TIMEOUT_EN
  // Never fire before a legitimately slow mac result could arrive.
  localparam int WD_LIM = (TIMEOUT > MAC_LAT) ? TIMEOUT : MAC_LAT + 1;
  localparam int WDW    = $clog2(WD_LIM + 1);

  logic [WDW-1:0] wd_cnt;

  assign wd_fire = (state_q == DRAIN) && !i_mac_valid &&
                   (wd_cnt == WDW'(WD_LIM - 1));

  // Drain watchdog: idle DRAIN cycles since last result; sticky flag.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (state_q != DRAIN || i_mac_valid) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + WDW'(1);
      if (start_ok) o_timeout <= 1'b0;
      else if (wd_fire && !drain_done) o_timeout <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAC_LAT, TIMEOUT};
  assign wd_fire    = 1'b0;
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// tb_mac_stream_ctrl: directed scoreboard bench for mac_stream_ctrl.
// Memory and 3-cycle mac models run alongside a linear stimulus block.
`timescale 1ns/1ps
module tb_mac_stream_ctrl;

  localparam int AW = 17;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW-1:0] i_len;
  logic          o_mem_ren;
  logic [AW-1:0] o_mem_addr;
  logic [23:0]   i_img_rdata = '0;
  logic [23:0]   i_wgt_rdata = '0;
  logic [71:0]   o_win_im;
  logic [35:0]   o_win_ker;
  logic          o_mac_valid;
  logic          i_mac_valid;
  logic [15:0]   i_mac_conv;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [15:0]   o_wr_data;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic          o_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb[$];

  int mv_runs = 0, mv_rise = 0, mv_len = 0;
  bit mv_prev = 0;
  logic [23:0] win_first = '0;
  int wr_seen = 0, done_seen = 0, err_seen = 0, ren_seen = 0;
  int last_wr_cyc = 0;

  logic        mac_v = 0, inj;
  logic [15:0] mac_d = '0;
  logic        p_v[2];
  logic [15:0] p_d[2];
  int          win_idx = 0, drop_idx = 0;
  bit          drop_en;

  assign i_mac_valid = mac_v | inj;
  assign i_mac_conv  = inj ? 16'hdead : mac_d;

  mac_stream_ctrl #(.AW(AW), .MAC_LAT(4), .TIMEOUT(64)) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .o_mem_ren(o_mem_ren), .o_mem_addr(o_mem_addr),
    .i_img_rdata(i_img_rdata), .i_wgt_rdata(i_wgt_rdata),
    .o_win_im(o_win_im), .o_win_ker(o_win_ker),
    .o_mac_valid(o_mac_valid), .i_mac_valid(i_mac_valid),
    .i_mac_conv(i_mac_conv), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] img_b(int r, int k);
    return 8'(k + r);
  endfunction

  function automatic logic [7:0] wgt_b(int r, int k);
    return 8'(k * (3 + 2 * r) + 165 + r);
  endfunction

  function automatic logic [15:0] exp_conv(int j);
    logic [15:0] s = '0;
    logic [7:0]  w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        w = wgt_b(r, j + c);
        s += 16'(img_b(r, j + c)) * 16'(w[3:0]);
      end
    return s;
  endfunction

  function automatic logic [15:0] win_conv(logic [71:0] im,
                                           logic [35:0] ker);
    logic [15:0] s = '0;
    for (int k = 0; k < 9; k++)
      s += 16'(im[8*k +: 8]) * 16'(ker[4*k +: 4]);
    return s;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Column memory: data valid the cycle after a read enable.
  always @(posedge clk) begin
    if (o_mem_ren) begin
      i_img_rdata <= {img_b(2, int'(o_mem_addr)),
                      img_b(1, int'(o_mem_addr)),
                      img_b(0, int'(o_mem_addr))};
      i_wgt_rdata <= {wgt_b(2, int'(o_mem_addr)),
                      wgt_b(1, int'(o_mem_addr)),
                      wgt_b(0, int'(o_mem_addr))};
    end
  end

  // Mac model, 3-cycle latency, optional single dropped result.
  always @(posedge clk) begin
    p_v[0] <= o_mac_valid && !(drop_en && win_idx == drop_idx);
    p_d[0] <= win_conv(o_win_im, o_win_ker);
    if (o_mac_valid) win_idx <= win_idx + 1;
    p_v[1] <= p_v[0];
    p_d[1] <= p_d[0];
    mac_v  <= p_v[1];
    mac_d  <= p_d[1];
  end

  // Output monitor and scoreboard pop.
  always @(negedge clk) begin
    if (o_mac_valid) begin
      if (!mv_prev) begin
        mv_runs++;
        mv_rise = cyc;
        mv_len = 0;
        win_first = o_win_im[23:0];
      end
      mv_len++;
    end
    mv_prev = o_mac_valid;
    if (o_done) done_seen++;
    if (o_err) err_seen++;
    if (o_mem_ren) ren_seen++;
    if (o_wr_en) begin
      wr_seen++;
      last_wr_cyc = cyc;
      chk("wr_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", o_wr_addr, e.a);
        chk("wr_data", o_wr_data, e.d);
      end
    end
  end

  task automatic push_exp(int cnt);
    exp_t e;
    for (int j = 0; j < cnt; j++) begin
      e.a = AW'(j);
      e.d = exp_conv(j);
      sb.push_back(e);
    end
  endtask

  task automatic start_pass(input int n, output int c0);
    @(negedge clk);
    i_len = AW'(n);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_pass(input int n);
    int r0, w0, d0, n0, c0;
    bit ok;
    r0 = mv_runs; w0 = wr_seen; d0 = done_seen; n0 = ren_seen;
    push_exp(n - 2);
    start_pass(n, c0);
    chk("busy_start", o_busy, 1);
    wait_done(n + 80, ok);
    chk("done_reached", ok, 1);
    chk("busy_done", o_busy, 0);
    @(negedge clk);
    chk("mv_rise", mv_rise - c0, 4);
    chk("mv_len", mv_len, n - 2);
    chk("mv_runs", mv_runs - r0, 1);
    chk("wr_count", wr_seen - w0, n - 2);
    chk("done_count", done_seen - d0, 1);
    chk("ren_count", ren_seen - n0, n);
    chk("sb_empty", sb.size(), 0);
    chk("win_first", win_first, 24'h020100);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1);
  end

  initial begin
    int c0, d0, e0, n0, w0, r0;
    bit ok;
    i_rst = 1'b1; i_start = 1'b0; i_len = '0;
    inj = 1'b0; drop_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {o_mem_ren, o_mem_addr, o_win_im, o_win_ker, o_mac_valid,
         o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err,
         o_timeout}, 0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a long read phase.
    d0 = done_seen;
    push_exp(126);
    start_pass(128, c0);
    repeat (10) @(negedge clk);
    chk("mid_ren_active", o_mem_ren, 1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_outputs",
        {o_mem_ren, o_mem_addr, o_win_im, o_win_ker, o_mac_valid,
         o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err,
         o_timeout}, 0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", done_seen - d0, 0);
    chk("mid_rst_idle", o_busy, 0);
    sb.delete();

    // Nominal and minimum-length passes.
    run_pass(128);
    run_pass(3);

    // Rejected short start.
    e0 = err_seen; n0 = ren_seen;
    start_pass(2, c0);
    chk("short_busy", o_busy, 0);
    repeat (5) @(negedge clk);
    chk("short_err", err_seen - e0, 1);
    chk("short_no_ren", ren_seen - n0, 0);
    chk("short_idle", o_busy, 0);

    // Start held high across a whole pass.
    n0 = ren_seen; w0 = wr_seen; d0 = done_seen; r0 = mv_runs;
    push_exp(3);
    push_exp(3);
    @(negedge clk);
    i_len = AW'(5);
    i_start = 1'b1;
    wait_done(100, ok);
    chk("hold_done1", ok, 1);
    chk("hold_ren_first", ren_seen - n0, 5);
    wait_done(100, ok);
    chk("hold_done2", ok, 1);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_ren_total", ren_seen - n0, 10);
    chk("hold_wr_total", wr_seen - w0, 6);
    chk("hold_done_total", done_seen - d0, 2);
    chk("hold_runs", mv_runs - r0, 2);
    chk("hold_sb_empty", sb.size(), 0);

    // Stray mac result while idle.
    w0 = wr_seen;
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_inject_no_wr", wr_seen - w0, 0);

    // Back-to-back passes.
    run_pass(5);
    run_pass(4);

`ifdef MAC_CTRL_TIMEOUT_EN
    // Last result lost: watchdog ends the pass.
    w0 = wr_seen; d0 = done_seen;
    push_exp(7);
    drop_idx = win_idx + 7;
    drop_en = 1'b1;
    start_pass(10, c0);
    wait_done(400, ok);
    chk("to_done", ok, 1);
    chk("to_flag", o_timeout, 1);
    chk("to_gap", cyc - last_wr_cyc, 64);
    drop_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_sticky", o_timeout, 1);
    chk("to_wr_count", wr_seen - w0, 7);
    chk("to_done_count", done_seen - d0, 1);
    chk("to_sb_empty", sb.size(), 0);
    run_pass(3);
`endif
    chk("timeout_clear", o_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_stream_ctrl.md
Name: mac_stream_ctrl

Overview:
- Sequencer that feeds the 3x3 `mac` datapath from packed image and weight column memories.
- Generates read addresses and builds the 9-pixel and 9-weight sliding windows.
- Drives the MAC `i_valid` input and writes the MAC results to an output buffer.
- Runs one convolution pass of N columns per `i_start` and reports completion; replaces the hand-built sequencing currently done in simulation.

Parameters:
- AW, 17, address width for column memories and output buffer.
- MAC_LAT, 4, maximum MAC latency (o_mac_valid to i_mac_valid) in cycles; used by the drain watchdog only.
- TIMEOUT, 64, drain watchdog limit in cycles (MAC_CTRL_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  start a pass; sampled only in IDLE.
- i_len  in  AW  number of columns N; N>=3 required.
- o_mem_ren  out  1  column read enable.
- o_mem_addr  out  AW  column read address.
- i_img_rdata  in  24  image column: [7:0] row1, [15:8] row2, [23:16] row3; valid the cycle after o_mem_ren.
- i_wgt_rdata  in  24  weight column: [3:0] row1, [11:8] row2, [19:16] row3; same timing as image.
- o_win_im  out  72  pixel window; im k (1..9) at bits [8k-1:8k-8].
- o_win_ker  out  36  weight window; ker k at bits [4k-1:4k-4].
- o_mac_valid  out  1  window valid, drives mac i_valid.
- i_mac_valid  in  1  mac o_valid.
- i_mac_conv  in  16  mac o_conv.
- o_wr_en  out  1  output buffer write strobe.
- o_wr_addr  out  AW  output buffer address.
- o_wr_data  out  16  output buffer data.
- o_busy  out  1  pass in progress.
- o_done  out  1  one-cycle pulse at pass end.
- o_err  out  1  one-cycle pulse on rejected start (N<3).
- o_timeout  out  1  sticky watchdog flag (MAC_CTRL_TIMEOUT_EN only).

Behaviour:
- Reset: i_rst asynchronously clears every register, output and counter to 0; FSM goes to IDLE. A mid-pass reset abandons the pass; no o_done is produced.
- All outputs are registered.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - i_start with i_len>=3: latch N, clear counters, go to READ, o_busy=1.
  - i_start with i_len<3: o_err pulses for 1 cycle, stay in IDLE.
- READ:
  - o_mem_ren=1 with o_mem_addr = 0,1,...,N-1 on consecutive cycles.
  - After address N-1 is issued, go to DRAIN.
  - i_start is ignored while busy.
- Column load:
  - An internal rvalid is ren delayed 1 cycle. On each rvalid edge, every row shifts toward the oldest slot.
  - Row1: im1<=im2, im2<=im3, im3<=new. Same pattern for im4-6, im7-9 and all ker slots.
  - Weights take the low nibble of each byte lane.
  - Window registers hold their value when rvalid=0.
- Window valid: o_mac_valid = registered (rvalid && columns_loaded>=2 before this shift).
  - First o_mac_valid rises 4 clocks after the edge that samples i_start.
  - It then stays high exactly N-2 consecutive cycles with no gaps.
- Result write:
  - Each i_mac_valid while busy gives, next cycle, o_wr_en=1, o_wr_data=i_mac_conv, o_wr_addr=wr_cnt; then wr_cnt increments.
  - i_mac_valid in IDLE or DONE is ignored, with no write.
- DRAIN: wait until wr_cnt reaches N-2 (count includes the write currently being performed), then go to DONE.
- DONE: o_done=1 for 1 cycle, o_busy=0, return to IDLE. A new i_start is accepted from the following cycle.
- Counters are AW bits and do not wrap within a pass, since N <= 2^AW-1.

Optional Feature:
- MAC_CTRL_TIMEOUT_EN defined:
  - The watchdog counts DRAIN cycles since the last i_mac_valid (or since entering DRAIN).
  - On reaching TIMEOUT it sets o_timeout (sticky until reset or next accepted start) and forces DONE, with o_done pulsed.
- Not defined:
  - DRAIN waits indefinitely.
  - o_timeout is tied to 0 and the watchdog logic is absent.

Test Plan:
- Reset check: assert i_rst mid-READ with N=128 -> all outputs 0 immediately; IDLE; no o_done.
- Nominal pass: N=128, memory word k = {8'hk+2, 8'hk+1, 8'hk}, MAC model with 3-cycle latency -> o_mac_valid high 126 consecutive cycles starting 4 clocks after start; first window im1..im3 = 0,1,2; 126 writes to addresses 0..125; single o_done.
- Minimum length: N=3 -> exactly one o_mac_valid cycle and one write at address 0, then o_done; N=2 -> o_err pulse, no ren, o_busy stays 0.
- Start abuse: i_start held high throughout a pass -> second pass begins only after o_done; i_mac_valid pulse injected in IDLE -> no o_wr_en.
- Back-to-back passes: N=5 then N=4 -> write addresses restart at 0; write counts 3 then 2.
- Timeout (MAC_CTRL_TIMEOUT_EN): MAC model drops last result with N=10 -> o_timeout=1 and o_done exactly TIMEOUT=64 cycles after the 7th write.
